mem_req_arb_n: RTL and testbench
================================

Name: mem_req_arb_n

Overview:
- Parametrised N-channel block-transfer arbiter between requesters (instr cache, data cache, FT accelerator buffer, future channels) and the host memory controller word interface.
- Accepts one block read or block write at a time and serialises it into BLK_W/WORD_W word beats.
- Returns a completion pulse (with assembled read block) to the granted channel.
- Priority is fixed or round-robin (see Optional Feature).

Parameters:
- NUM_CH, 3, number of requester channels; channel 0 is highest fixed priority.
- ADDR_W, 32, byte address width.
- WORD_W, 32, memory-controller data bus width.
- BLK_W, 512, block width; must be an integer multiple of WORD_W.
- BEATS, BLK_W/WORD_W (derived, localparam), word beats per block.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  NUM_CH  per-channel request; held until req_ready
- req_we  in  NUM_CH  1 = block write, 0 = block read
- req_addr  in  NUM_CH*ADDR_W  per-channel block byte address; low log2(BLK_W/8) bits ignored
- req_wdata  in  NUM_CH*BLK_W  per-channel write block
- req_ready  out  NUM_CH  one-hot grant/accept pulse
- rsp_valid  out  NUM_CH  one-hot completion pulse
- rsp_rdata  out  BLK_W  assembled read block, valid with rsp_valid
- mem_op  out  2  MEM_IDLE / MEM_READ / MEM_WRITE
- mem_addr  out  ADDR_W  beat byte address
- mem_wdata  out  WORD_W  beat write data
- mem_rdata  in  WORD_W  beat read data
- mem_rd_valid  in  1  read beat complete, mem_rdata valid
- mem_tx_done  in  1  write beat accepted by host
- busy  out  1  transfer in progress

Behaviour:
- Reset (sync, rst high at posedge): state=IDLE, beat counter=0, RR pointer=0. All outputs 0; rsp_rdata cleared. Reset mid-transfer aborts it silently: no rsp_valid, and the channel must re-request.
- FSM states: IDLE, BEAT, RESP.
- IDLE:
  - If any req_valid, the picker selects channel g; req_ready[g]=1 combinationally in this cycle.
  - At the clock edge, latch g, req_we[g], the aligned address, and req_wdata[g]; beat counter=0; go to BEAT.
  - With no req_valid, stay in IDLE.
- BEAT:
  - mem_op = MEM_WRITE if latched we, else MEM_READ.
  - mem_addr = base + beat*(WORD_W/8).
  - mem_wdata = latched block word[beat], LSW first.
  - mem_op holds steady until the beat completes.
  - A read beat completes only on mem_rd_valid; mem_rdata is written into assembly slot[beat]. mem_tx_done is ignored for reads.
  - A write beat completes only on mem_tx_done; mem_rd_valid is ignored for writes.
  - On completion with beat<BEATS-1: increment beat, stay in BEAT; new address is driven next cycle.
  - On completion with beat==BEATS-1: go to RESP.
- RESP:
  - rsp_valid[g]=1 for exactly one cycle; mem_op=MEM_IDLE.
  - rsp_rdata holds the assembled block for reads and is stable until the next RESP; it is don't-care for writes.
  - Next state is IDLE, so there is a minimum one-cycle gap between transfers.
- busy = (state != IDLE).
- Latency with a 1-cycle-responding memory and BEATS=16: grant at cycle 0, beats at cycles 1..16, rsp_valid at cycle 17, next grant no earlier than cycle 18.
- Deassertion of req_valid after grant is ignored; the transfer runs to completion. New req_valid during a transfer waits.
- Address arithmetic is modulo 2^ADDR_W; no block crosses alignment because low bits are forced to 0.
- Beat counter width is $clog2(BEATS), minimum 1.

Optional Feature:
- Macro MEM_ARB_RR_EN.
- Defined: round-robin picker. Search starts at the RR pointer; after a grant to g, pointer = (g+1) mod NUM_CH. The pointer updates only on a grant.
- Undefined: fixed priority, lowest index wins; no pointer register exists.

Decomposition:
- Package mem_arb_pkg: mem_op_t enum (MEM_IDLE=2'b00, MEM_READ=2'b01, MEM_WRITE=2'b11) and arb_state_t enum (IDLE, BEAT, RESP).
- Sub-module mem_arb_grant: req vector in, one-hot grant out. It holds the RR pointer under MEM_ARB_RR_EN and is purely combinational otherwise.

Test Plan:
- Ch1 read at 0x1000_0040, mem returns rdata=beat index one cycle after each op -> mem_addr steps 0x1000_0040..0x1000_007C; rsp_valid[1] at cycle 17; rsp_rdata word k = k.
- Ch0 write of 0xA5A5_0000+k per word, tx_done delayed 3 cycles per beat -> mem_wdata matches each beat; mem_op and mem_addr stable while waiting; rsp_valid[0] after 16 beats.
- req_valid=3'b111 held, fixed priority -> grants 0,0,0... If MEM_ARB_RR_EN -> grants 0,1,2,0.
- rst asserted at beat 5 of a read -> next cycle all outputs 0, state IDLE, no rsp_valid; a re-request completes normally.
- Read beat with spurious mem_tx_done, and write beat with spurious mem_rd_valid -> no beat advance.
- req_addr=0x1000_007F -> first mem_addr=0x1000_0040; addr 0xFFFF_FFC0 read -> last beat 0xFFFF_FFFC.

Source files
------------

// File: rtl/mem_req_arb_n_pkg.sv
// Shared types for the mem_req_arb_n block-transfer arbiter.
// Optional build macro used by this slice: MEM_ARB_RR_EN (round-robin picker).
package mem_arb_pkg;

   typedef enum logic [1:0] {
      MEM_IDLE  = 2'b00,
      MEM_READ  = 2'b01,
      MEM_WRITE = 2'b11
   } mem_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BEAT = 2'b01,
      RESP = 2'b10
   } arb_state_t;

endpackage

// File: rtl/mem_req_arb_n_if.sv
// Requester/memory-controller bundle for mem_req_arb_n.
// slave = arbiter side, master = requester/memory side.
interface mem_req_arb_n_if #(
   parameter int NUM_CH = 3,
   parameter int ADDR_W = 32,
   parameter int WORD_W = 32,
   parameter int BLK_W  = 512
);
   import mem_arb_pkg::*;

   logic [NUM_CH-1:0]        req_valid;
   logic [NUM_CH-1:0]        req_we;
   logic [NUM_CH*ADDR_W-1:0] req_addr;
   logic [NUM_CH*BLK_W-1:0]  req_wdata;
   logic [NUM_CH-1:0]        req_ready;
   logic [NUM_CH-1:0]        rsp_valid;
   logic [BLK_W-1:0]         rsp_rdata;
   mem_op_t                  mem_op;
   logic [ADDR_W-1:0]        mem_addr;
   logic [WORD_W-1:0]        mem_wdata;
   logic [WORD_W-1:0]        mem_rdata;
   logic                     mem_rd_valid;
   logic                     mem_tx_done;
   logic                     busy;

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata,
      input  mem_rdata, mem_rd_valid, mem_tx_done,
      output req_ready, rsp_valid, rsp_rdata,
      output mem_op, mem_addr, mem_wdata, busy
   );

   modport master (
      output req_valid, req_we, req_addr, req_wdata,
      output mem_rdata, mem_rd_valid, mem_tx_done,
      input  req_ready, rsp_valid, rsp_rdata,
      input  mem_op, mem_addr, mem_wdata, busy
   );

endinterface

// File: rtl/mem_req_arb_n_grant.sv
// Channel picker for mem_req_arb_n: request vector in, one-hot grant out.
// With MEM_ARB_RR_EN defined the search starts at a round-robin pointer that
// advances past the winner on each accepted grant; otherwise lowest index wins
// and the block is purely combinational.
module mem_arb_grant #(
   parameter int NUM_CH = 3
) (
`ifdef MEM_ARB_RR_EN
   input  logic              clk,
   input  logic              rst,
   input  logic              grant_en,
`endif
   input  logic [NUM_CH-1:0] req,
   output logic [NUM_CH-1:0] grant
);

`ifdef MEM_ARB_RR_EN
   localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int unsigned N = NUM_CH;

   logic [PTR_W-1:0] ptr_q, ptr_d;

   // Rotating search from the pointer; pointer moves only when a grant is taken.
   always_comb begin
      int unsigned idx;
      logic        found;
      grant = '0;
      ptr_d = ptr_q;
      found = 1'b0;
      idx   = 0;
      for (int unsigned i = 0; i < N; i++) begin
         idx = (32'(ptr_q) + i) % N;
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            if (grant_en) begin
               ptr_d = PTR_W'((idx + 1) % N);
            end
         end
      end
   end

   // Round-robin pointer register.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`else
   // Fixed priority: lowest requesting index wins.
   always_comb begin
      logic found;
      grant = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (!found && req[i]) begin
            grant[i] = 1'b1;
            found    = 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/mem_req_arb_n.sv
// N-channel block-transfer arbiter: accepts one block read/write at a time and
// serialises it into BLK_W/WORD_W word beats on the memory-controller port,
// then pulses rsp_valid (with the assembled read block) to the granted channel.
// Build macro: MEM_ARB_RR_EN selects round-robin instead of fixed priority.
module mem_req_arb_n
   import mem_arb_pkg::*;
#(
   parameter int NUM_CH = 3,
   parameter int ADDR_W = 32,
   parameter int WORD_W = 32,
   parameter int BLK_W  = 512
) (
   input  logic           clk,
   input  logic           rst,
   mem_req_arb_n_if.slave bus
);

   localparam int                BEATS      = BLK_W / WORD_W;
   localparam int                BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BLK_W / 8 - 1);
   localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(WORD_W / 8);
   localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BEATS - 1);

   arb_state_t        state_q, state_d;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic [NUM_CH-1:0] ch_q, ch_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [BLK_W-1:0]  wblk_q, wblk_d;
   logic [BLK_W-1:0]  asm_q, asm_d;
   logic [BLK_W-1:0]  rdata_q, rdata_d;

   logic [NUM_CH-1:0] grant;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [BLK_W-1:0]  sel_wdata;
   logic              beat_done;

`ifdef MEM_ARB_RR_EN
   logic grant_en;
   assign grant_en = (state_q == IDLE);

   mem_arb_grant #(.NUM_CH(NUM_CH)) u_grant (
      .clk      (clk),
      .rst      (rst),
      .grant_en (grant_en),
      .req      (bus.req_valid),
      .grant    (grant)
   );
`else
   mem_arb_grant #(.NUM_CH(NUM_CH)) u_grant (
      .req   (bus.req_valid),
      .grant (grant)
   );
`endif

   // Route the granted channel's request fields to the latch inputs.
   always_comb begin
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (grant[i]) begin
            sel_we    = bus.req_we[i];
            sel_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
            sel_wdata = bus.req_wdata[i*BLK_W +: BLK_W];
         end
      end
   end

   // Transfer FSM next-state and output decode.
   always_comb begin
      state_d   = state_q;
      beat_d    = beat_q;
      ch_d      = ch_q;
      we_d      = we_q;
      base_d    = base_q;
      wblk_d    = wblk_q;
      asm_d     = asm_q;
      rdata_d   = rdata_q;
      beat_done = 1'b0;

      bus.req_ready = '0;
      bus.rsp_valid = '0;
      bus.mem_op    = MEM_IDLE;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;

      unique case (state_q)
         IDLE: begin
            if (|grant) begin
               bus.req_ready = grant;
               ch_d          = grant;
               we_d          = sel_we;
               base_d        = sel_addr & ALIGN_MASK;
               wblk_d        = sel_wdata;
               beat_d        = '0;
               state_d       = BEAT;
            end
         end
         BEAT: begin
            bus.mem_op    = we_q ? MEM_WRITE : MEM_READ;
            bus.mem_addr  = base_q + ADDR_W'(beat_q) * WORD_BYTES;
            bus.mem_wdata = wblk_q[int'(beat_q)*WORD_W +: WORD_W];
            beat_done     = we_q ? bus.mem_tx_done : bus.mem_rd_valid;
            if (!we_q && bus.mem_rd_valid) begin
               asm_d[int'(beat_q)*WORD_W +: WORD_W] = bus.mem_rdata;
            end
            if (beat_done) begin
               if (beat_q == LAST_BEAT) begin
                  state_d = RESP;
                  // Publish the block (including the final word) so rsp_rdata
                  // stays stable while the next transfer reassembles.
                  if (!we_q) begin
                     rdata_d = asm_d;
                  end
               end else begin
                  beat_d = beat_q + 1'b1;
               end
            end
         end
         RESP: begin
            bus.rsp_valid = ch_q;
            state_d       = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.busy      = (state_q != IDLE);
   assign bus.rsp_rdata = rdata_q;

   // State, beat counter and block registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         beat_q  <= '0;
         ch_q    <= '0;
         we_q    <= 1'b0;
         base_q  <= '0;
         wblk_q  <= '0;
         asm_q   <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         ch_q    <= ch_d;
         we_q    <= we_d;
         base_q  <= base_d;
         wblk_q  <= wblk_d;
         asm_q   <= asm_d;
         rdata_q <= rdata_d;
      end
   end

endmodule

// File: tb/tb_mem_req_arb_n.sv
// Directed scoreboard bench for mem_req_arb_n with a behavioural memory model.
// Honours MEM_ARB_RR_EN for the grant-order expectations.
`timescale 1ns/1ps
module tb_mem_req_arb_n;
   import mem_arb_pkg::*;

   localparam int NUM_CH = 3;
   localparam int ADDR_W = 32;
   localparam int WORD_W = 32;
   localparam int BLK_W  = 512;
   localparam int BEATS  = BLK_W / WORD_W;

   logic clk = 1'b0;
   logic rst = 1'b1;

   mem_req_arb_n_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .WORD_W(WORD_W), .BLK_W(BLK_W)) bus ();

   mem_req_arb_n #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .WORD_W(WORD_W), .BLK_W(BLK_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } beat_t;
   typedef struct { int ch; logic we; logic [BLK_W-1:0] rdata; int lat; } rsp_t;
   typedef struct { int ch; int gap; } gnt_t;

   beat_t exp_beat[$];
   rsp_t  exp_rsp[$];
   gnt_t  exp_gnt[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_gcyc = 0;
   int gcount = 0;
   int beats_done = 0;
   int wait_cnt = 0;
   int mem_lat = 0;
   logic spur = 1'b0;
   logic [31:0] salt = '0;

   task automatic chk(input string tag, input logic [BLK_W-1:0] obs, input logic [BLK_W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [NUM_CH-1:0] onehot(input int ch);
      return NUM_CH'(1) << ch;
   endfunction

   always @(posedge clk) cyc++;

   // Monitor + memory responder, evaluated mid-cycle.
   always @(negedge clk) begin
      beat_t b;
      rsp_t  r;
      gnt_t  g;
      logic  done;
      done = 1'b0;
      if (rst) begin
         bus.mem_rd_valid = 1'b0;
         bus.mem_tx_done  = 1'b0;
         bus.mem_rdata    = '0;
         wait_cnt         = 0;
      end else begin
         if (bus.req_ready != '0) begin
            chk("grant_expected", BLK_W'(exp_gnt.size() != 0), 1);
            if (exp_gnt.size() != 0) begin
               g = exp_gnt.pop_front();
               chk("grant_chan", bus.req_ready, onehot(g.ch));
               if (g.gap != 0) chk("grant_gap", cyc - last_gcyc, g.gap);
            end
            last_gcyc = cyc;
            gcount++;
         end
         if (bus.rsp_valid != '0) begin
            chk("rsp_expected", BLK_W'(exp_rsp.size() != 0), 1);
            if (exp_rsp.size() != 0) begin
               r = exp_rsp.pop_front();
               chk("rsp_chan", bus.rsp_valid, onehot(r.ch));
               if (!r.we) chk("rsp_rdata", bus.rsp_rdata, r.rdata);
               chk("rsp_latency", cyc - last_gcyc, r.lat);
            end
         end
         if (bus.mem_op != MEM_IDLE) begin
            chk("beat_expected", BLK_W'(exp_beat.size() != 0), 1);
            if (exp_beat.size() != 0) begin
               b = exp_beat[0];
               chk("beat_op", bus.mem_op, b.we ? MEM_WRITE : MEM_READ);
               chk("beat_addr", bus.mem_addr, b.addr);
               if (b.we) chk("beat_wdata", bus.mem_wdata, b.wdata);
               done = (wait_cnt >= mem_lat);
               if (done) begin
                  exp_beat.delete(0);
                  wait_cnt = 0;
                  beats_done++;
               end else begin
                  wait_cnt++;
               end
            end
            bus.mem_rdata    = salt + 32'(bus.mem_addr[5:2]);
            bus.mem_rd_valid = (bus.mem_op == MEM_READ)  ? done : spur;
            bus.mem_tx_done  = (bus.mem_op == MEM_WRITE) ? done : spur;
         end else begin
            bus.mem_rd_valid = 1'b0;
            bus.mem_tx_done  = 1'b0;
            bus.mem_rdata    = '0;
            wait_cnt         = 0;
         end
      end
   end

   task automatic expect_xfer(input int ch, input logic we, input logic [31:0] addr,
                              input logic [31:0] wbase, input int gap);
      beat_t b;
      rsp_t  r;
      gnt_t  g;
      logic [31:0] base;
      base    = addr & 32'hFFFF_FFC0;
      r.rdata = '0;
      for (int k = 0; k < BEATS; k++) begin
         b.we    = we;
         b.addr  = base + 32'(4 * k);
         b.wdata = wbase + 32'(k);
         exp_beat.push_back(b);
         r.rdata[k*32 +: 32] = salt + 32'(k);
      end
      r.ch  = ch;
      r.we  = we;
      r.lat = 1 + BEATS * (mem_lat + 1);
      exp_rsp.push_back(r);
      g.ch  = ch;
      g.gap = gap;
      exp_gnt.push_back(g);
   endtask

   task automatic load_req(input int ch, input logic we, input logic [31:0] addr, input logic [31:0] wbase);
      bus.req_we[ch]              = we;
      bus.req_addr[ch*32 +: 32]   = addr;
      for (int k = 0; k < BEATS; k++) begin
         bus.req_wdata[ch*BLK_W + k*32 +: 32] = wbase + 32'(k);
      end
   endtask

   task automatic send(input int ch, input logic we, input logic [31:0] addr, input logic [31:0] wbase);
      int   n;
      logic got;
      n   = 0;
      got = 1'b0;
      @(posedge clk); #1;
      load_req(ch, we, addr, wbase);
      bus.req_valid[ch] = 1'b1;
      while (!got && n < 400) begin
         @(negedge clk);
         if (bus.req_ready[ch]) got = 1'b1;
         n++;
      end
      chk("grant_timeout", BLK_W'(got), 1);
      @(posedge clk); #1;
      bus.req_valid[ch] = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int   n;
      logic ok;
      n  = 0;
      ok = 1'b0;
      while (!ok && n < 2000) begin
         @(negedge clk); #1;
         ok = (exp_beat.size() == 0) && (exp_rsp.size() == 0) && !bus.busy;
         n++;
      end
      chk(tag, BLK_W'(ok), 1);
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_op"},    bus.mem_op,    MEM_IDLE);
      chk({tag, "_addr"},  bus.mem_addr,  0);
      chk({tag, "_wdata"}, bus.mem_wdata, 0);
      chk({tag, "_ready"}, bus.req_ready, 0);
      chk({tag, "_rsp"},   bus.rsp_valid, 0);
      chk({tag, "_rdata"}, bus.rsp_rdata, 0);
      chk({tag, "_busy"},  bus.busy,      0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int g0;
      int n;
      int b0;
      int ch_ord[4];

      bus.req_valid = '0;
      bus.req_we    = '0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_quiet("reset");
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk_quiet("post_reset");

      // Ch1 read, single-cycle memory, rdata word k = k
      salt = 32'h0; mem_lat = 0;
      expect_xfer(1, 1'b0, 32'h1000_0040, 32'h0, 0);
      send(1, 1'b0, 32'h1000_0040, 32'h0);
      wait_done("rd_ch1_done");

      // Ch0 write, tx_done delayed 3 cycles per beat
      mem_lat = 3;
      expect_xfer(0, 1'b1, 32'h0000_8000, 32'hA5A5_0000, 0);
      send(0, 1'b1, 32'h0000_8000, 32'hA5A5_0000);
      wait_done("wr_ch0_done");
      mem_lat = 0;

      // All channels requesting from a fresh reset
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      salt = 32'h100;
`ifdef MEM_ARB_RR_EN
      ch_ord = '{0, 1, 2, 0};
`else
      ch_ord = '{0, 0, 0, 0};
`endif
      for (int i = 0; i < 4; i++) begin
         expect_xfer(ch_ord[i], 1'b0, 32'h4000_0000 + 32'(ch_ord[i] * 32'h1000), 32'h0, (i == 0) ? 0 : 18);
      end
      for (int c = 0; c < NUM_CH; c++) load_req(c, 1'b0, 32'h4000_0000 + 32'(c * 32'h1000), 32'h0);
      g0 = gcount;
      n  = 0;
      bus.req_valid = '1;
      while (gcount < g0 + 4 && n < 500) begin
         @(posedge clk);
         n++;
      end
      chk("prio_grant_count", BLK_W'(gcount - g0), 4);
      #1 bus.req_valid = '0;
      wait_done("prio_done");

      // Reset during beat 5 of a read aborts silently
      salt = 32'h0;
      b0 = beats_done;
      expect_xfer(2, 1'b0, 32'h3000_0000, 32'h0, 0);
      send(2, 1'b0, 32'h3000_0000, 32'h0);
      n = 0;
      while (beats_done < b0 + 5 && n < 100) begin
         @(posedge clk);
         n++;
      end
      chk("abort_reach_beat5", BLK_W'(beats_done - b0), 5);
      #1 rst = 1'b1;
      exp_beat.delete();
      exp_rsp.delete();
      @(posedge clk);
      @(negedge clk);
      chk_quiet("abort");
      @(posedge clk); #1 rst = 1'b0;
      repeat (4) @(posedge clk);
      expect_xfer(2, 1'b0, 32'h3000_0000, 32'h0, 0);
      send(2, 1'b0, 32'h3000_0000, 32'h0);
      wait_done("rerequest_done");

      // Spurious completion strobes of the wrong kind
      spur = 1'b1; mem_lat = 2; salt = 32'h7700;
      expect_xfer(2, 1'b0, 32'h5000_0000, 32'h0, 0);
      send(2, 1'b0, 32'h5000_0000, 32'h0);
      wait_done("spur_rd_done");
      expect_xfer(1, 1'b1, 32'h5000_1000, 32'h1234_0000, 0);
      send(1, 1'b1, 32'h5000_1000, 32'h1234_0000);
      wait_done("spur_wr_done");
      spur = 1'b0; mem_lat = 0;

      // Address alignment and top-of-space wrap
      salt = 32'h55;
      expect_xfer(0, 1'b0, 32'h1000_007F, 32'h0, 0);
      send(0, 1'b0, 32'h1000_007F, 32'h0);
      wait_done("align_done");
      expect_xfer(1, 1'b0, 32'hFFFF_FFC0, 32'h0, 0);
      send(1, 1'b0, 32'hFFFF_FFC0, 32'h0);
      wait_done("top_addr_done");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
